// File: rtl/uart_cmd_pkg.sv
// Shared constants and state encodings for the host-to-FPGA UART command path.
package uart_cmd_pkg;

    localparam logic [7:0] CMD_READ = 8'h52;
    localparam int unsigned CMD_LEN = 5;

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} rx_state_t;
    typedef enum logic [1:0] {P_IDLE, P_ADDR, P_ISSUE} parse_state_t;

endpackage

// File: rtl/uart_rx_core.sv
// 8N1 UART receiver: 2-flop synchroniser, mid-bit sampling FSM, framed-byte and
// frame-error strobes.
module uart_rx_core
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_DIV = 434
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       i_uart_rx,
    output logic       rx_valid,
    output logic [7:0] rx_byte,
    output logic       frame_err
);

    localparam int unsigned CNT_W = $clog2(CLK_DIV + 1);
    localparam logic [CNT_W-1:0] CNT_HALF = CNT_W'(CLK_DIV / 2);
    localparam logic [CNT_W-1:0] CNT_FULL = CNT_W'(CLK_DIV);
    localparam logic [CNT_W-1:0] CNT_ONE  = CNT_W'(1);

    logic [1:0]       sync_q;
    logic             rx_s;
    logic             rx_prev_q;
    rx_state_t        state_q;
    logic [CNT_W-1:0] cnt_q;
    logic [2:0]       bit_idx_q;
    logic [7:0]       shift_q;

    assign rx_s = sync_q[1];

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            // Line idles high, so the synchroniser resets to 1 to avoid a false start edge.
            sync_q    <= 2'b11;
            rx_prev_q <= 1'b1;
            state_q   <= IDLE;
            cnt_q     <= '0;
            bit_idx_q <= '0;
            shift_q   <= '0;
            rx_byte   <= '0;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
        end else begin
            sync_q    <= {sync_q[0], i_uart_rx};
            rx_prev_q <= rx_s;
            rx_valid  <= 1'b0;
            frame_err <= 1'b0;
            case (state_q)
                IDLE: begin
                    if (rx_prev_q && !rx_s) begin
                        state_q <= START;
                        cnt_q   <= CNT_HALF;
                    end
                end
                START: begin
                    if (cnt_q == CNT_ONE) begin
                        if (rx_s) begin
                            state_q <= IDLE;
                        end else begin
                            state_q   <= DATA;
                            cnt_q     <= CNT_FULL;
                            bit_idx_q <= '0;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                DATA: begin
                    if (cnt_q == CNT_ONE) begin
                        shift_q <= {rx_s, shift_q[7:1]};
                        cnt_q   <= CNT_FULL;
                        if (bit_idx_q == 3'd7) begin
                            state_q <= STOP;
                        end else begin
                            bit_idx_q <= bit_idx_q + 3'd1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                STOP: begin
                    if (cnt_q == CNT_ONE) begin
                        // Back to IDLE mid stop bit so a back-to-back start edge is caught.
                        state_q <= IDLE;
                        if (rx_s) begin
                            rx_byte  <= shift_q;
                            rx_valid <= 1'b1;
                        end else begin
                            frame_err <= 1'b1;
                        end
                    end else begin
                        cnt_q <= cnt_q - CNT_ONE;
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/uart_rx_sector_cmd.sv
// UART command receiver: parses 'R' + 32-bit big-endian sector number and drives the
// SD reader read request (rstart / rsector_no / rdone).
module uart_rx_sector_cmd
    import uart_cmd_pkg::*;
#(
    parameter int unsigned CLK_DIV      = 434,
    parameter int unsigned TIMEOUT_BITS = 20
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        i_uart_rx,
    output logic        rx_valid,
    output logic [7:0]  rx_byte,
    output logic        frame_err,
    output logic        cmd_err,
    output logic        rstart,
    output logic [31:0] rsector_no,
    input  logic        rdone
);

    localparam int unsigned TMO   = CLK_DIV * TIMEOUT_BITS;
    localparam int unsigned TMO_W = $clog2(TMO);
    localparam logic [TMO_W-1:0] TMO_LOAD = TMO_W'(TMO - 1);
    localparam logic [1:0] LAST_IDX = 2'(CMD_LEN - 2);

    parse_state_t     pstate_q;
    logic [31:0]      shadow_q;
    logic [1:0]       idx_q;
    logic [TMO_W-1:0] tmo_q;

    uart_rx_core #(
        .CLK_DIV (CLK_DIV)
    ) u_rx (
        .clk       (clk),
        .rst_n     (rst_n),
        .i_uart_rx (i_uart_rx),
        .rx_valid  (rx_valid),
        .rx_byte   (rx_byte),
        .frame_err (frame_err)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            pstate_q   <= P_IDLE;
            shadow_q   <= '0;
            idx_q      <= '0;
            tmo_q      <= '0;
            rstart     <= 1'b0;
            rsector_no <= '0;
            cmd_err    <= 1'b0;
        end else begin
            cmd_err <= 1'b0;
            case (pstate_q)
                P_IDLE: begin
                    if (rx_valid) begin
                        if (rx_byte == CMD_READ) begin
                            pstate_q <= P_ADDR;
                            idx_q    <= '0;
                            tmo_q    <= TMO_LOAD;
                        end else begin
                            cmd_err <= 1'b1;
                        end
                    end
                end
                P_ADDR: begin
                    if (frame_err) begin
                        pstate_q <= P_IDLE;
                        shadow_q <= '0;
                    end else if (rx_valid) begin
                        shadow_q <= {shadow_q[23:0], rx_byte};
                        idx_q    <= idx_q + 2'd1;
                        tmo_q    <= TMO_LOAD;
                        if (idx_q == LAST_IDX) begin
                            rsector_no <= {shadow_q[23:0], rx_byte};
                            rstart     <= 1'b1;
                            pstate_q   <= P_ISSUE;
                        end
                    end else if (tmo_q == '0) begin
                        cmd_err  <= 1'b1;
                        pstate_q <= P_IDLE;
                        shadow_q <= '0;
                    end else begin
                        tmo_q <= tmo_q - TMO_W'(1);
                    end
                end
                P_ISSUE: begin
                    // A byte arriving while a request is outstanding is dropped, even alongside rdone.
                    if (rx_valid) begin
                        cmd_err <= 1'b1;
                    end
                    if (rdone) begin
                        rstart   <= 1'b0;
                        pstate_q <= P_IDLE;
                    end
                end
                default: pstate_q <= P_IDLE;
            endcase
        end
    end

endmodule

// File: doc/uart_rx_sector_cmd.md
Name:
uart_rx_sector_cmd

Overview:
- Host-to-FPGA command path: the UART receiver paired with the existing sector-dump UART transmitter.
- Deserialises bytes on the host-PC TXD line and parses 5-byte read-sector commands.
- Drives the SD reader's read-command interface (rstart / rsector_no / rdone), so the host chooses which sector is dumped instead of a fixed sector 0.

Parameters:
- CLK_DIV, 434, clk cycles per UART bit (50 MHz / 434 ≈ 115200 baud); must be ≥ 4.
- TIMEOUT_BITS, 20, inter-byte timeout inside a command, in bit periods.

Ports:
- clk  input  1  system clock, 0–50 MHz
- rst_n  input  1  asynchronous active-low reset
- i_uart_rx  input  1  serial in from host TXD; idle high; asynchronous to clk
- rx_valid  output  1  one-cycle strobe: rx_byte holds a correctly framed byte
- rx_byte  output  8  last received byte
- frame_err  output  1  one-cycle strobe: stop bit sampled low
- cmd_err  output  1  one-cycle strobe: byte rejected or command timed out
- rstart  output  1  read request to SD reader; level signal
- rsector_no  output  32  sector number for the request
- rdone  input  1  SD reader completion strobe

Behaviour:
- Reset: all outputs 0 (rsector_no = 0, rx_byte = 0); RX in IDLE, parser in P_IDLE. Reset mid-frame discards any partial byte or command.
- Input path: i_uart_rx passes through a 2-flop synchroniser; all logic uses the synchronised value.
- RX FSM:
  - IDLE: on a synchronised high→low transition go to START and load bit counter = CLK_DIV/2.
  - START: at counter expiry, sample the line. If high (glitch), return to IDLE with no strobe. If low, go to DATA.
  - DATA: sample 8 bits, LSB first, each CLK_DIV cycles after the previous sample (mid-bit).
  - STOP: sample after CLK_DIV cycles. If high: rx_byte updated and rx_valid = 1 for exactly one cycle (the cycle after the sample). If low: frame_err = 1 for one cycle; rx_byte unchanged; no rx_valid.
  - After STOP, return to IDLE immediately (mid stop bit). The next start edge is accepted at once; back-to-back bytes are supported.
- Parser (consumes rx_valid):
  - P_IDLE: byte 0x52 ('R') → P_ADDR, byte index 0. Any other byte → cmd_err pulse, stay in P_IDLE.
  - P_ADDR: shift 4 bytes MSB-first into a shadow register. On the 4th byte: rsector_no ← shadow, rstart ← 1 (cycle after that rx_valid), go to P_ISSUE.
  - P_ISSUE: rstart held high. On rdone = 1: rstart = 0 on the next edge, go to P_IDLE. Any rx_valid here → cmd_err pulse, byte dropped, rsector_no unchanged. If rdone and rx_valid arrive in the same cycle, rdone is honoured and the byte is dropped with cmd_err.
- Timeout: in P_ADDR, a counter of CLK_DIV × TIMEOUT_BITS cycles is restarted on each rx_valid. Expiry → cmd_err pulse, P_IDLE, shadow discarded.
- frame_err while in P_ADDR → P_IDLE, no cmd_err. frame_err in other states has no parser effect.
- rdone outside P_ISSUE is ignored.
- rsector_no changes only on command acceptance and is stable while rstart = 1.
- rx_valid / rx_byte remain observable in every parser state (debug/echo use).

Decomposition:
- Package uart_cmd_pkg:
  - CMD_READ = 8'h52
  - CMD_LEN = 5
  - enums rx_state_t {IDLE, START, DATA, STOP} and parse_state_t {P_IDLE, P_ADDR, P_ISSUE}
- Sub-module uart_rx_core: synchroniser, RX FSM, rx_valid / rx_byte / frame_err.
- The parser and timeout live in uart_rx_sector_cmd.

Test Plan:
- Bench setting for all tests: CLK_DIV = 8, TIMEOUT_BITS = 20.
- Send 0xA5 with a valid frame → exactly one rx_valid, rx_byte = 0xA5, no frame_err, cmd_err pulse (non-'R' byte in P_IDLE).
- Send 0x3C with the stop bit forced low → one frame_err pulse, no rx_valid, rx_byte retains its previous value. Then drive a 3-cycle low glitch → no strobes at all.
- Send 52 00 00 01 2C back-to-back → rstart rises the cycle after the 5th rx_valid with rsector_no = 0x0000012C. Hold rdone low 100 cycles → rstart stays high. Pulse rdone → rstart = 0 next cycle.
- While rstart is high, send 52 → cmd_err pulse, rsector_no stays 0x0000012C. Assert rdone in the same cycle as that rx_valid → rstart drops, parser in P_IDLE.
- Send 52 00, then idle 200 cycles → one cmd_err at the timeout. Then send 52 00 00 00 07 → rstart = 1, rsector_no = 0x00000007.
- Assert rst_n low mid-way through the 3rd address byte → all outputs 0. After release, 52 FF FF FF FE → rsector_no = 0xFFFFFFFE.
